// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants one of mem/alu/mul per cycle and registers the winning write.
// WB_STARVE_EN enables the multiplier aging FSM (NORMAL/BOOST); without it priority is fixed mem > alu > mul.
module wb_port_arbiter #(
  parameter int DW           = 16,
  parameter int AW           = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mul_valid,
  input  logic [AW-1:0] mul_addr,
  input  logic [DW-1:0] mul_data,
  output logic          mul_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          mul_starved
);

  logic          boost;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

`ifdef WB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {NORMAL, BOOST} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!mul_valid || mul_ready) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    // State mirrors the saturated counter so BOOST coincides with cnt==LIMIT.
    state_d = (starve_cnt_d == LIMIT) ? BOOST : NORMAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign boost       = (state_q == BOOST);
  assign mul_starved = boost;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign boost       = 1'b0;
  assign mul_starved = 1'b0;
`endif

  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    mul_ready = 1'b0;
    if (!reset) begin
      if (boost && mul_valid) begin
        mul_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end else if (mul_valid) begin
        mul_ready = 1'b1;
      end
    end
  end

  always_comb begin
    xfer     = mem_ready | alu_ready | mul_ready;
    win_addr = mul_addr;
    win_data = mul_data;
    if (mem_ready) begin
      win_addr = mem_addr;
      win_data = mem_data;
    end else if (alu_ready) begin
      win_addr = alu_addr;
      win_data = alu_data;
    end
  end

  always_comb begin
    // Writes to register 0 are consumed but never enabled.
    rf_we_d    = xfer && (win_addr != '0);
    rf_waddr_d = xfer ? win_addr : rf_waddr_q;
    rf_wdata_d = xfer ? win_data : rf_wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single write, conflicts, register 0,
// starvation (both macro builds) and reset mid-stream.
module tb_wb_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_valid = 1'b0, alu_valid = 1'b0, mul_valid = 1'b0;
  logic [AW-1:0] mem_addr = '0, alu_addr = '0, mul_addr = '0;
  logic [DW-1:0] mem_data = '0, alu_data = '0, mul_data = '0;
  logic          mem_ready, alu_ready, mul_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          mul_starved;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mul_valid(mul_valid), .mul_addr(mul_addr), .mul_data(mul_data), .mul_ready(mul_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mul_starved(mul_starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    check({tag, "_we"}, 32'(rf_we), 32'(we));
    check({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_wdata"}, 32'(rf_wdata), 32'(d));
  endtask

  task automatic check_rdy(input string tag, input logic m, input logic a, input logic u);
    check({tag, "_rdy"}, {29'd0, mem_ready, alu_ready, mul_ready}, {29'd0, m, a, u});
  endtask

  initial begin
    // Reset with traffic pending.
    mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 16'h0F0F;
    #2;
    check_rdy("rst_init", 1'b0, 1'b0, 1'b0);
    check_rf("rst_init", 1'b0, '0, '0);
    check("rst_starved", 32'(mul_starved), 32'd0);
    mem_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Single ALU write.
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'h1234;
    #1;
    check_rdy("alu_single", 1'b0, 1'b1, 1'b0);
    step();
    alu_valid = 1'b0;
    check_rf("alu_wr", 1'b1, 4'd5, 16'h1234);
    step();
    check_rf("alu_idle", 1'b0, 4'd5, 16'h1234);

    // mem vs alu conflict.
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 16'h5555;
    #1;
    check_rdy("conf_c0", 1'b1, 1'b0, 1'b0);
    step();
    mem_valid = 1'b0;
    check_rf("conf_c1", 1'b1, 4'd3, 16'hAAAA);
    #1;
    check_rdy("conf_c1", 1'b0, 1'b1, 1'b0);
    step();
    alu_valid = 1'b0;
    check_rf("conf_c2", 1'b1, 4'd4, 16'h5555);
    step();
    check_rf("conf_c3", 1'b0, 4'd4, 16'h5555);

    // Register 0 write is accepted but not enabled.
    mem_valid = 1'b1; mem_addr = 4'd0; mem_data = 16'hFFFF;
    #1;
    check_rdy("zero", 1'b1, 1'b0, 1'b0);
    step();
    mem_valid = 1'b0;
    check_rf("zero_wr", 1'b0, 4'd0, 16'hFFFF);
    step();

    // Starvation pressure: mem and alu always valid.
    mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
    mul_valid = 1'b1; mul_addr = 4'd9; mul_data = 16'h9999;
`ifdef WB_STARVE_EN
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("starve_rdy_c%0d", i), 32'(mul_ready), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("starve_flag_c%0d", i), 32'(mul_starved), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("starve_mem_c%0d", i), 32'(mem_ready), (i == 4) ? 32'd0 : 32'd1);
      step();
      if (i == 4) check_rf("starve_mulwr", 1'b1, 4'd9, 16'h9999);
    end
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("nostarve_rdy_c%0d", i), 32'(mul_ready), 32'd0);
      check($sformatf("nostarve_flag_c%0d", i), 32'(mul_starved), 32'd0);
      step();
      check($sformatf("nostarve_wr_c%0d", i), 32'(rf_waddr), 32'd1);
    end
`endif
    mem_valid = 1'b0; alu_valid = 1'b0; mul_valid = 1'b0;
    step();
    step();

    // Reset mid-stream with alu held behind mem.
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h2222;
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'hBEEF;
    step();
    mem_valid = 1'b0;
    check_rf("mid_pre", 1'b1, 4'd2, 16'h2222);
    reset = 1'b1;
    #1;
    check_rf("mid_rst", 1'b0, '0, '0);
    check_rdy("mid_rst", 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check_rdy("mid_rel", 1'b0, 1'b1, 1'b0);
    step();
    alu_valid = 1'b0;
    check_rf("mid_wr", 1'b1, 4'd7, 16'hBEEF);
    step();
    check_rf("mid_idle", 1'b0, 4'd7, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
